// File: rtl/uart_report_tx.sv
// UART report serializer: snapshots BCD digits, sends them as ASCII with optional
// separators and a CR LF trailer, 8N1, triggered by a pulse or a periodic timer.
module uart_report_tx #(
  parameter int                    CLK_FREQ   = 12000000,
  parameter int                    BAUD       = 9600,
  parameter int                    NUM_DIGITS = 7,
  parameter logic [NUM_DIGITS-1:0] SEP_MASK   = 7'b0001000,
  parameter logic [7:0]            SEP_CHAR   = 8'h20,
  parameter int                    PERIOD_CYC = 0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              drop_cnt,
  output logic                    uart_txd
);

  function automatic int popcount(input logic [14:0] m);
    int c;
    c = 0;
    for (int i = 0; i < 15; i++) begin
      if (m[i]) c++;
    end
    return c;
  endfunction

  localparam int BAUD_DIV  = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int NUM_BYTES = NUM_DIGITS + popcount(15'(SEP_MASK)) + 2;
  localparam int XW        = $clog2(NUM_BYTES + 1);
  localparam int DW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [XW-1:0] BYTE_LAST = XW'(NUM_BYTES - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  typedef enum logic [1:0] {SEL_DIG, SEL_SEP, SEL_CR, SEL_LF} sel_e;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [DW-1:0] dig_idx_q, dig_idx_d;
  sel_e          sel_q, sel_d;
  logic [XW-1:0] byte_idx_q, byte_idx_d;
  logic [7:0]    drop_q, drop_d;
  logic          done_q, done_d;
  logic          txd_q, txd_d;
  logic [3:0]    snap_q [NUM_DIGITS];

  logic       tick;
  logic       req;
  logic       load_snap;
  logic       bit_end;
  logic [3:0] cur_dig;
  logic [7:0] cur_byte;

  generate
    if (PERIOD_CYC > 0) begin : g_timer
      localparam int            PW      = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
      localparam logic [PW-1:0] PER_MAX = PW'(PERIOD_CYC - 1);
      logic [PW-1:0] per_q, per_d;

      // Free-running: keeps counting while a frame is in flight.
      always_comb begin
        per_d = per_q + 1'b1;
        if (per_q == PER_MAX) per_d = '0;
      end

      always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) per_q <= '0;
        else            per_q <= per_d;
      end

      assign tick = (per_q == PER_MAX);
    end else begin : g_no_timer
      assign tick = 1'b0;
    end
  endgenerate

  assign req       = start | tick;
  assign load_snap = (state_q == S_IDLE) && req;
  assign bit_end   = (bit_cnt_q == BIT_LAST);
  assign cur_dig   = snap_q[dig_idx_q];

  always_comb begin
    cur_byte = 8'h0A;
    case (sel_q)
      SEL_DIG: cur_byte = (cur_dig <= 4'd9) ? (8'h30 + {4'h0, cur_dig}) : 8'h3F;
      SEL_SEP: cur_byte = SEP_CHAR;
      SEL_CR:  cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  // NOTE: every next-state signal gets a default first so no latch is inferred,
  // and uses blocking '=' here; only the always_ff blocks use '<='.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    dig_idx_d  = dig_idx_q;
    sel_d      = sel_q;
    byte_idx_d = byte_idx_q;
    drop_d     = drop_q;
    done_d     = 1'b0;

    if (state_q != S_IDLE && req && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d    = S_START;
          bit_cnt_d  = '0;
          dig_idx_d  = '0;
          sel_d      = SEL_DIG;
          byte_idx_d = '0;
        end
      end
      S_START: begin
        // Byte is loaded at the end of the start bit, once the snapshot is valid.
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          bit_idx_d = '0;
          shift_d   = cur_byte;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        // The byte-select decision happens in the last stop-bit cycle: no gap.
        if (bit_end) begin
          bit_cnt_d = '0;
          if (byte_idx_q == BYTE_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = S_START;
            byte_idx_d = byte_idx_q + 1'b1;
            case (sel_q)
              SEL_DIG: begin
                if (SEP_MASK[dig_idx_q])        sel_d = SEL_SEP;
                else if (dig_idx_q == DIG_LAST) sel_d = SEL_CR;
                else                            dig_idx_d = dig_idx_q + 1'b1;
              end
              SEL_SEP: begin
                if (dig_idx_q == DIG_LAST) begin
                  sel_d = SEL_CR;
                end else begin
                  sel_d     = SEL_DIG;
                  dig_idx_d = dig_idx_q + 1'b1;
                end
              end
              default: sel_d = SEL_LF;
            endcase
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    endcase

    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      dig_idx_q  <= '0;
      sel_q      <= SEL_DIG;
      byte_idx_q <= '0;
      drop_q     <= '0;
      done_q     <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      dig_idx_q  <= dig_idx_d;
      sel_q      <= sel_d;
      byte_idx_q <= byte_idx_d;
      drop_q     <= drop_d;
      done_q     <= done_d;
      txd_q      <= txd_d;
    end
  end

  // NOTE: the snapshot array is always written before it is read, so it carries no reset.
  always_ff @(posedge sys_clk) begin
    if (load_snap) begin
      for (int i = 0; i < NUM_DIGITS; i++) snap_q[i] <= digits[4*(NUM_DIGITS-1-i) +: 4];
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign drop_cnt = drop_q;
  assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_report_tx.sv
// Bench for uart_report_tx: a serial receiver model feeds a byte scoreboard, plus
// directed checks of framing, drops, reset and the periodic timer.
module tb_uart_report_tx;

  localparam int DIV   = 104;
  localparam int HALF  = 52;
  localparam int FRAME = 10400;

  logic        clk = 1'b0;
  logic        rst_a = 1'b0;
  logic        rst_bc = 1'b0;
  logic        start_a = 1'b0;
  logic        start_bc = 1'b0;
  logic [27:0] digits_a = 28'h1234256;
  logic [27:0] digits_bc = 28'h1234256;

  logic       busy_a, done_a, txd_a;
  logic [7:0] drop_a;
  logic       busy_b, done_b, txd_b;
  logic [7:0] drop_b;
  logic       busy_c, done_c, txd_c;
  logic [7:0] drop_c;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit bc_done = 1'b0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_report_tx #(.CLK_FREQ(12000000), .BAUD(115200)) u_a (
    .sys_clk(clk), .sys_rst_n(rst_a), .start(start_a), .digits(digits_a),
    .busy(busy_a), .done(done_a), .drop_cnt(drop_a), .uart_txd(txd_a));

  uart_report_tx #(.CLK_FREQ(12000000), .BAUD(115200), .PERIOD_CYC(5000)) u_b (
    .sys_clk(clk), .sys_rst_n(rst_bc), .start(start_bc), .digits(digits_bc),
    .busy(busy_b), .done(done_b), .drop_cnt(drop_b), .uart_txd(txd_b));

  uart_report_tx #(.CLK_FREQ(12000000), .BAUD(115200), .PERIOD_CYC(20000)) u_c (
    .sys_clk(clk), .sys_rst_n(rst_bc), .start(start_bc), .digits(digits_bc),
    .busy(busy_c), .done(done_c), .drop_cnt(drop_c), .uart_txd(txd_c));

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push_chars(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic push_frame(input string s);
    push_chars(s);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Called at posedge+1; start is sampled by the next edge.
  task automatic issue_start(input string nm, output int t0);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    t0 = cyc;
    check({nm, " txd low after 1 cycle"}, 32'(txd_a), 0);
    check({nm, " busy after 1 cycle"}, 32'(busy_a), 1);
  endtask

  task automatic wait_done(input string nm, input int t0);
    bit got;
    int gaps;
    got  = 1'b0;
    gaps = 0;
    for (int i = 0; i < 12000 && !got; i++) begin
      @(posedge clk); #1;
      if (done_a)       got = 1'b1;
      else if (!busy_a) gaps++;
    end
    check({nm, " done seen"}, 32'(got), 1);
    check({nm, " frame length"}, cyc - t0, FRAME);
    check({nm, " busy gaps"}, gaps, 0);
    check({nm, " busy low at done"}, 32'(busy_a), 0);
  endtask

  // Serial receiver for instance A: samples mid-bit on the falling clock edge.
  int         rx_st = 0;
  int         rx_cnt = 0;
  int         rx_k = 0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clk) begin
    if (!rst_a) begin
      rx_st = 0;
    end else if (rx_st == 0) begin
      if (txd_a == 1'b0) begin
        rx_st  = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == HALF) begin
        check("rx start bit", 32'(txd_a), 0);
      end else if (rx_cnt > HALF && (rx_cnt - HALF) % DIV == 0) begin
        rx_k = (rx_cnt - HALF) / DIV;
        if (rx_k <= 8) begin
          rx_byte[rx_k-1] = txd_a;
        end else begin
          check("rx stop bit", 32'(txd_a), 1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx byte: got 0x%0h, nothing expected", rx_byte);
          end else begin
            check("rx byte", 32'(rx_byte), 32'(exp_q.pop_front()));
          end
          rx_st = 0;
        end
      end
    end
  end

  // Periodic-timer instances: frame start cycles and drop counts are hand-derived.
  initial begin
    int b_exp[3];
    int b_drop[3];
    int b_rise, b_done, c_rise;
    logic b_prev, c_prev;
    b_exp  = '{5000, 20000, 35000};
    b_drop = '{2, 4, 6};
    b_rise = 0;
    b_done = 0;
    c_rise = 0;
    b_prev = 1'b0;
    c_prev = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_bc = 1'b1;
    for (int n = 1; n <= 46000; n++) begin
      @(posedge clk); #1;
      if (busy_b && !b_prev) begin
        if (b_rise < 3) check("B frame start cycle", n, b_exp[b_rise]);
        b_rise++;
      end
      if (done_b) begin
        if (b_done < 3) check("B drops at done", 32'(drop_b), b_drop[b_done]);
        b_done++;
      end
      if (busy_c && !c_prev) begin
        check("C frame start cycle", n, (c_rise + 1) * 20000);
        c_rise++;
      end
      b_prev = busy_b;
      c_prev = busy_c;
    end
    check("B frame count", b_rise, 3);
    check("B done count", b_done, 3);
    check("C frame count", c_rise, 2);
    check("C drop_cnt", 32'(drop_c), 0);
    bc_done = 1'b1;
  end

  initial begin
    int t0;
    int dc;

    repeat (5) @(posedge clk);
    #1;
    check("reset txd", 32'(txd_a), 1);
    check("reset busy", 32'(busy_a), 0);
    check("reset done", 32'(done_a), 0);
    check("reset drop_cnt", 32'(drop_a), 0);
    rst_a = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("idle txd", 32'(txd_a), 1);

    // Frame 1: default digits and separator.
    push_frame("1234 256");
    issue_start("f1", t0);
    wait_done("f1", t0);
    @(posedge clk); #1;
    check("f1 done single pulse", 32'(done_a), 0);
    check("f1 drop_cnt", 32'(drop_a), 0);

    // Frame 2: invalid digit, digits changed mid-frame, two rejected starts.
    digits_a = 28'h12A4256;
    push_frame("12?4 256");
    issue_start("f2", t0);
    repeat (50) begin @(posedge clk); #1; end
    digits_a = 28'h9999999;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (49) begin @(posedge clk); #1; end
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("f2 drop_cnt mid-frame", 32'(drop_a), 2);
    push_frame("9999 999");
    wait_done("f2", t0);
    check("f2 drop_cnt at done", 32'(drop_a), 2);

    // Frame 3 is requested in the done cycle of frame 2.
    issue_start("f3", t0);
    wait_done("f3", t0);
    check("f3 drop_cnt", 32'(drop_a), 2);

    // Frame 4 is abandoned by a one-cycle reset during its fourth byte.
    digits_a = 28'h1234256;
    push_chars("123");
    issue_start("f4", t0);
    repeat (100) begin @(posedge clk); #1; end
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("f4 drop_cnt before reset", 32'(drop_a), 3);
    while (cyc - t0 < 3600) begin @(posedge clk); #1; end
    rst_a = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b1;
    check("mid reset txd", 32'(txd_a), 1);
    check("mid reset busy", 32'(busy_a), 0);
    check("mid reset drop_cnt", 32'(drop_a), 0);
    dc = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (done_a) dc++;
    end
    check("no done after reset", dc, 0);

    push_frame("1234 256");
    issue_start("f5", t0);
    wait_done("f5", t0);
    check("f5 drop_cnt", 32'(drop_a), 0);

    // Frame 6: 300 rejected requests saturate the drop counter.
    push_frame("1234 256");
    issue_start("f6", t0);
    repeat (20) begin @(posedge clk); #1; end
    start_a = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("drop_cnt after 100", 32'(drop_a), 100);
    repeat (200) @(posedge clk);
    #1;
    start_a = 1'b0;
    check("drop_cnt saturated", 32'(drop_a), 255);
    wait_done("f6", t0);
    check("f6 drop_cnt at done", 32'(drop_a), 255);

    for (int i = 0; i < 60000 && !bc_done; i++) @(posedge clk);
    check("timer bench finished", 32'(bc_done), 1);
    check("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
